// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, FSM encoding and defaults for the load/store memory master
//
// Purpose : common definitions imported by lsu_mem_master and lsu_lane_align.
// Contents: SIZE_B/SIZE_H/SIZE_W access size codes, lsu_state_t FSM encoding,
//           LSU_ADDR_LIMIT default byte-address bound.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [31:0] LSU_ADDR_LIMIT = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational load lane extract/extend and store lane merge
//
// Purpose : selects the addressed byte/halfword lane of a memory word for loads
//           (zero- or sign-extended) and builds the merged word for sub-word stores.
// Ports   : size        access size code (SIZE_B/SIZE_H/SIZE_W)
//           is_unsigned 1 = zero-extend load lane, 0 = sign-extend
//           lane        byte address bits [1:0]
//           ld_word     word currently read from memory (load source)
//           old_word    previously captured word (store merge base)
//           st_data     right-aligned store data
//           ld_data     extended load result
//           st_word     full word to write back
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] ld_word,
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word[{lane, 3'b000} +: 8];
    ld_half = ld_word[{lane[1], 4'b0000} +: 16];
    ld_data = ld_word;
    st_word = st_data;
    case (size)
      SIZE_B: begin
        ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
        st_word = old_word;
        st_word[{lane, 3'b000} +: 8] = st_data[7:0];
      end
      SIZE_H: begin
        ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
        st_word = old_word;
        st_word[{lane[1], 4'b0000} +: 16] = st_data[15:0];
      end
      default: begin
        ld_data = ld_word;
        st_word = st_data;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - CPU load/store unit master to a single-cycle data memory
//
// Purpose : accepts one load/store at a time, checks it, performs the memory
//           read and/or write and returns a one-cycle response.
// Config  : LSU_SUBWORD_EN defined enables byte/halfword accesses (including the
//           read-merge-write path for sub-word stores); undefined, only word
//           accesses are legal and everything else is answered with resp_err.
// Ports   : clk, rst_n (async active-low)
//           req_valid/req_ready handshake with req_we, req_size, req_unsigned,
//           req_addr, req_wdata
//           resp_valid pulse with resp_rdata, resp_err
//           mem_read, mem_write, address (word aligned), write_data, read_data
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = LSU_ADDR_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  lsu_state_t  state, state_nxt;
  logic        live;      // low through reset, high from the first edge after release
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] data_q;    // extended load result, or old word for a sub-word store
  logic        accept, err_now;
  logic [31:0] ld_data, st_word;

  assign req_ready = live && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    err_now = (req_size == 2'b11)
            || ((req_size == SIZE_H) && req_addr[0])
            || ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00))
            || (req_addr >= ADDR_LIMIT);
`ifndef LSU_SUBWORD_EN
    if (req_size != SIZE_W) err_now = 1'b1;
`endif
  end

  lsu_lane_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .lane        (addr_q[1:0]),
    .ld_word     (read_data),
    .old_word    (data_q),
    .st_data     (wdata_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      live    <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_W;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= err_now;
        data_q  <= '0;
      end else if (state == READ) begin
        data_q <= we_q ? read_data : ld_data;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (err_now)
            state_nxt = RESP;
          else if (!req_we)
            state_nxt = READ;
`ifdef LSU_SUBWORD_EN
          else if (req_size == SIZE_W)
            state_nxt = WRITE;
          else
            state_nxt = READ;
`else
          else
            state_nxt = WRITE;
`endif
        end
      end
      READ: begin
        mem_read = 1'b1;
        address  = {addr_q[31:2], 2'b00};
`ifdef LSU_SUBWORD_EN
        state_nxt = we_q ? WRITE : RESP;
`else
        state_nxt = RESP;
`endif
      end
      WRITE: begin
        mem_write  = 1'b1;
        address    = {addr_q[31:2], 2'b00};
        write_data = (size_q == SIZE_W) ? wdata_q : st_word;
        state_nxt  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'h0 : data_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - scoreboard bench for lsu_mem_master with a behavioural memory model
module tb_lsu_mem_master;

  localparam logic [31:0] LIMIT = 32'h0000_1000;
`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, address, write_data, read_data;

  lsu_mem_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        preload;

  assign read_data = mem[address[11:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[32'h100 >> 2] <= 32'h0000_0004;
      mem[32'h104 >> 2] <= 32'h0000_0005;
    end else if (mem_write) begin
      mem[address[11:2]] <= write_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   nrd = 0;
  int   nwr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: applies the access rules directly to ref_mem in issue order.
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int sh;
    logic [31:0] w, m, lane;
    e.rdata = 0; e.nrd = 0; e.nwr = 0; e.wword = 0;
    e.waddr = a & 32'hFFFF_FFFC;
    e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
         || (a >= LIMIT) || (!SUB && sz != 2'd2);
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    w  = ref_mem[a[11:2]];
    sh = (sz == 2'd2) ? 0 : (sz == 2'd1) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
    m  = (sz == 2'd2) ? 32'hFFFF_FFFF : (sz == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF;
    if (!we) begin
      lane = (w >> sh) & m;
      if (!uns && sz != 2'd2 && lane[(sz == 2'd1) ? 15 : 7]) lane = lane | ~m;
      e.rdata = lane;
      e.nrd   = 1;
      e.lat   = 2;
    end else begin
      e.wword = (w & ~(m << sh)) | ((wd << sh) & (m << sh));
      ref_mem[a[11:2]] = e.wword;
      e.nwr = 1;
      e.nrd = (sz == 2'd2) ? 0 : 1;
      e.lat = 2 + e.nrd;
    end
    return e;
  endfunction

  // Monitor: strobe checks and response scoreboard.
  initial forever begin
    exp_t e;
    int a;
    @(negedge clk);
    if (!rst_n) begin
      nrd = 0;
      nwr = 0;
    end else begin
      if (mem_read || mem_write) begin
        check("strobe_excl", {31'b0, mem_read & mem_write}, 32'h0);
        if (exp_q.size() > 0) check("mem_addr", address, exp_q[0].waddr);
      end
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        if (exp_q.size() > 0) check("write_data", write_data, exp_q[0].wword);
      end
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("spurious_resp", {31'b0, resp_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          check("latency", cyc - a, e.lat);
          check("n_mem_read", nrd, e.nrd);
          check("n_mem_write", nwr, e.nwr);
        end
        nrd = 0;
        nwr = 0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    e = model(we, sz, uns, a, wd);
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    // Scramble fields while busy; the DUT must use its latched copy.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 32'h0);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'h0);
    check({tag, "_resp"}, {30'b0, resp_valid, resp_err}, 32'h0);
    check({tag, "_rdata"}, resp_rdata, 32'h0);
    check({tag, "_strobes"}, {30'b0, mem_read, mem_write}, 32'h0);
    check({tag, "_address"}, address, 32'h0);
    check({tag, "_wdata"}, write_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int k;
    rst_n = 1'b0; preload = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[32'h100 >> 2] = 32'h0000_0004;
    ref_mem[32'h104 >> 2] = 32'h0000_0005;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'b0, req_ready}, 32'h1);

    // Directed accesses.
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB);
    drain();
    check("mem_0x100", mem[32'h100 >> 2], SUB ? 32'h0000_AB04 : 32'h0000_0004);
    do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h106, 32'h0000_1234);
    drain();
    check("mem_0x104", mem[32'h104 >> 2], SUB ? 32'h1234_0005 : 32'h0000_0005);
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h103, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h108, 32'hDEAD_BEEF);
    do_req(1'b1, 2'd3, 1'b0, 32'h10C, 32'h1111_1111);
    drain();

    // Randomised traffic over a small window and around the address bound.
    for (int n = 0; n < 80; n++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'h0FF8 + $urandom_range(0, 15);
      else a = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    drain();

    // Reset during the READ phase abandons the access.
    @(negedge clk);
    req_valid = 1'b1; req_we = SUB; req_size = SUB ? 2'd0 : 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0000_0055;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_in_read", {31'b0, mem_read}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_abort", {31'b0, req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    check("mem_0x100_abort", mem[32'h100 >> 2], ref_mem[32'h100 >> 2]);

    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h100, 32'h0000_0077);
    drain();

    for (int i = 32'h100 >> 2; i < (32'h140 >> 2); i++)
      check("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_1000, is the byte address bound; an access at or above it is an error.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  request accepted on a clock edge where req_valid and req_ready are both high.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is an error.
REQ-008 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  access rejected; valid with resp_valid.
REQ-014 mem_read, mem_write  output  1 each  data memory strobes.
REQ-015 address  output  32  word-aligned byte address to memory, bits [1:0] = 0.
REQ-016 write_data  output  32  full word to memory.
REQ-017 read_data  input  32  combinational memory read data, valid in the same cycle as mem_read.

Function
REQ-018 FSM states are IDLE, READ, WRITE and RESP; req_ready is high only in IDLE.
REQ-019 On acceptance, error checks run in IDLE: misalignment (halfword addr[0]=1, word addr[1:0]!=0), req_size=11, or req_addr>=ADDR_LIMIT go directly to RESP with resp_err=1 and no memory strobe.
REQ-020 A load goes IDLE->READ->RESP; READ asserts mem_read for exactly one cycle, and the extracted, extended lane is registered at the end of READ.
REQ-021 A word store goes IDLE->WRITE->RESP; WRITE asserts mem_write with write_data=req_wdata for exactly one cycle.
REQ-022 A byte or halfword store goes IDLE->READ->WRITE->RESP.
  - READ captures the old word.
  - WRITE writes the old word with only the addressed lane(s) replaced.
REQ-023 RESP asserts resp_valid for one cycle and returns to IDLE; back-to-back requests are accepted no earlier than the cycle after RESP.
REQ-024 Latency from the acceptance edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
REQ-025 Request fields are latched at acceptance; changes to req_* while the FSM is busy are ignored.
REQ-026 mem_read and mem_write are never high in the same cycle; both are 0 in IDLE and RESP.
REQ-027 Byte lane is addr[1:0]; halfword lane is addr[1].

Reset
REQ-028 While rst_n=0, the state is IDLE and all of the following are 0: req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, address, write_data.
REQ-029 req_ready rises in the first cycle after rst_n deasserts.
REQ-030 Reset mid-operation abandons the access with no response; a WRITE cut off before its clock edge leaves memory unchanged.

Configuration
REQ-031 Macro LSU_SUBWORD_EN defined: byte and halfword accesses are supported as specified above.
REQ-032 LSU_SUBWORD_EN undefined: req_size!=10 gives resp_err=1, the READ->WRITE merge path is absent, and the READ state is used only by loads.

Structure
REQ-033 Package lsu_pkg holds the size codes (SIZE_B, SIZE_H, SIZE_W), the FSM state encoding and the default ADDR_LIMIT.
REQ-034 Sub-module lsu_lane_align is combinational and performs load lane extract/extend and store lane merge; it is instantiated once.

Verification
REQ-035 The bench memory is preloaded with word 0x100=0x00000004 and 0x104=0x00000005.
REQ-036 Load word 0x100 -> mem_read for 1 cycle with address=0x100; resp_rdata=0x00000004 with resp_valid 2 cycles after acceptance.
REQ-037 Store byte 0xAB to 0x101 -> read then write of 0x0000AB04 to 0x100; next load byte 0x101 signed returns 0xFFFFFFAB, unsigned returns 0x000000AB.
REQ-038 Store halfword 0x1234 to 0x106 -> word 0x104 becomes 0x12340005; resp_valid 3 cycles after acceptance.
REQ-039 Load word 0x102, load halfword 0x103, and load word 0x1000 -> each gives resp_err=1 one cycle after acceptance, resp_rdata=0, and no mem_read or mem_write.
REQ-040 rst_n pulsed low during the READ of a sub-word store to 0x100 -> no resp_valid; word 0x100 unchanged; req_ready=1 the cycle after release.
REQ-041 Build without LSU_SUBWORD_EN: store byte to 0x100 -> resp_err=1 and memory unchanged.
